writeback_unit: RTL
===================

# writeback_unit

Write-side sequencer for the register file's single write port. Merges single-cycle ALU results and variable-latency load returns into one registered `regwrite`/`rd`/`rd_data` stream. Loads are buffered in a small FIFO, and ALU results have priority. When a younger ALU write targets the same register as a queued load, that load is squashed. A starvation guard forces a drain slot so loads cannot wait forever. The block sits between execute/memory response and the register file write inputs.

## Interface
- `DEPTH`, 4: load FIFO entries, power of two, 2..16.
- `STARVE_LIMIT`, 8: consecutive blocked-head cycles before a drain slot is forced, 1..255.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `alu_valid` input 1: ALU result offered.
- `alu_ready` output 1: ALU result accepted when `alu_valid & alu_ready`.
- `alu_rd` input 5: ALU destination.
- `alu_data` input 32: ALU result.
- `ld_valid` input 1: load return offered.
- `ld_ready` output 1: load accepted when `ld_valid & ld_ready`.
- `ld_rd` input 5: load destination.
- `ld_data` input 32: load data.
- `regwrite` output 1: write strobe to the register file.
- `rd` output 5: write address.
- `rd_data` output 32: write data.
- `wb_count` output 32: writes issued. Present only with `WB_STATS_EN`.
- `squash_count` output 16: loads squashed. Present only with `WB_STATS_EN`.

## Operation
- **Load acceptance.** Accepted loads with `ld_rd != 0` are enqueued, each with a valid bit. Loads to x0 are accepted and discarded.
- **ALU acceptance.** Accepted ALU results are never queued. They go straight to the output register. ALU writes to x0 are accepted but produce `regwrite=0` and do not squash.
- **Squash.** An accepted ALU write with `alu_rd=X` (X≠0) clears the valid bit of every queued entry with rd X. This includes a load enqueued in the same cycle, because a same-cycle load is defined as older. Each cleared entry increments `squash_count`.
- **Port arbitration**, evaluated once per cycle:
  - Accepted ALU result with rd≠0: drives the write.
  - Otherwise, head valid: head drives the write and is popped.
  - Otherwise, head invalid (squashed): head is popped with no write.
  - Otherwise: `regwrite=0`.
- **Starvation counter.**
  - Increments in each cycle where the FIFO head is valid and an ALU write took the port.
  - Clears when the head drains, when the FIFO is empty, or on a forced slot.
  - When it reaches `STARVE_LIMIT`, `alu_ready` is 0 for exactly the next cycle. The head drains in that cycle, then the counter clears.
- **Handshakes.**
  - `ld_ready = (occupancy < DEPTH)`. There is no pass-through when full: a pop in the same cycle does not raise `ld_ready`.
  - Upstream holds `alu_*` stable while `alu_valid & ~alu_ready`.
- **Stats.** `wb_count` increments on every cycle with `regwrite=1`.

## Timing
- **Latency.**
  - ALU result accepted in cycle t: `regwrite` in cycle t+1.
  - Load accepted in cycle t into an empty FIFO with no competing ALU write: `regwrite` in cycle t+2.
- **Registered outputs.** `regwrite`, `rd`, `rd_data` and `alu_ready` are flops. `ld_ready` is decoded from the occupancy flop.
- **Reset values.** When `reset` is low, these are forced immediately and asynchronously:
  - `regwrite=0`, `rd=0`, `rd_data=0`, `alu_ready=1`.
  - FIFO empty, so `ld_ready=1`.
  - Starvation counter 0; `wb_count=0`, `squash_count=0`.
- **Reset mid-operation.** Queued loads are lost. The pointers wrap modulo `DEPTH`, and occupancy is `$clog2(DEPTH)+1` bits.
- **Simultaneous enqueue and pop.** Occupancy is unchanged. An enqueue into an empty FIFO cannot pop in the same cycle.
- **Counters.** `squash_count` saturates at 0xFFFF. `wb_count` wraps.

## Configuration
- `WB_STATS_EN` defined: `wb_count` and `squash_count` ports and counters exist as described.
- `WB_STATS_EN` undefined: both ports and all counter logic are omitted. All other behaviour is identical.

## Test plan
- **Reset values.** Assert reset mid-stream with 3 loads queued → outputs immediately 0, `ld_ready=1`, `alu_ready=1`. After release, no write occurs for the flushed loads.
- **ALU latency.** ALU rd=5, data=0xDEADBEEF in cycle t → `regwrite=1`, `rd=5`, `rd_data=0xDEADBEEF` in t+1. Load rd=6, data=0x1234 into an idle block → write in t+2.
- **Squash.** Load rd=7, data=0x11 queued behind ALU traffic, then ALU rd=7, data=0x22 → only 0x22 is written to x7. `squash_count=1`, and the squashed head pops with `regwrite=0`.
- **Full FIFO.** 4 loads with continuous ALU writes → `ld_ready=0` with 4 queued. The 5th `ld_valid` is held until a pop, with no loss or duplication.
- **Starvation.** FIFO holds one valid load and ALU is valid every cycle with `STARVE_LIMIT=8` → after 8 ALU writes, `alu_ready=0` for one cycle and the load is written in that cycle. ALU resumes the next cycle.
- **x0 handling.** ALU or load writes to rd=0 → accepted, `regwrite` stays 0, and nothing is squashed or enqueued.

Source files
------------

// File: rtl/writeback_unit.sv
// writeback_unit: merges single-cycle ALU results and FIFO-buffered load returns onto one register-file write port.
// Define WB_STATS_EN to build the wb_count / squash_count statistics ports and counters.
module writeback_unit #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        regwrite,
  output logic [4:0]  rd,
  output logic [31:0] rd_data
`ifdef WB_STATS_EN
  ,
  output logic [31:0] wb_count,
  output logic [15:0] squash_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [4:0]       ent_rd_q   [DEPTH];
  logic [4:0]       ent_rd_d   [DEPTH];
  logic [31:0]      ent_data_q [DEPTH];
  logic [31:0]      ent_data_d [DEPTH];
  logic [DEPTH-1:0] ent_vld_q;
  logic [DEPTH-1:0] ent_vld_d;
  logic [DEPTH-1:0] squash_hit_s;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    wr_ptr_d;
  logic [OW-1:0]    occ_q;
  logic [OW-1:0]    occ_d;
  logic [7:0]       starve_q;
  logic [7:0]       starve_d;
  logic             alu_ready_q;
  logic             alu_ready_d;
  logic             regwrite_q;
  logic             regwrite_d;
  logic [4:0]       rd_q;
  logic [4:0]       rd_d;
  logic [31:0]      rd_data_q;
  logic [31:0]      rd_data_d;

  logic             alu_acc_s;
  logic             alu_wr_s;
  logic             enq_s;
  logic             head_avail_s;
  logic             head_vld_s;
  logic             pop_s;
  logic             drain_s;

  // ld_ready comes straight from the occupancy flop, so a same-cycle pop never opens a full FIFO.
  assign ld_ready  = (occ_q < OW'(DEPTH));
  assign alu_ready = alu_ready_q;
  assign regwrite  = regwrite_q;
  assign rd        = rd_q;
  assign rd_data   = rd_data_q;

  // Handshake decode and write-port arbitration for the current cycle.
  always_comb begin
    alu_acc_s    = alu_valid & alu_ready_q;
    alu_wr_s     = alu_acc_s & (alu_rd != 5'd0);
    enq_s        = ld_valid & ld_ready & (ld_rd != 5'd0);
    head_avail_s = (occ_q != {OW{1'b0}});
    head_vld_s   = ent_vld_q[rd_ptr_q];
    pop_s        = head_avail_s & ~alu_wr_s;
    drain_s      = pop_s & head_vld_s;
  end

  // Load FIFO next state: pop, enqueue, then squash (a same-cycle enqueue counts as older).
  always_comb begin
    ent_rd_d   = ent_rd_q;
    ent_data_d = ent_data_q;
    ent_vld_d  = ent_vld_q;
    if (pop_s) begin
      ent_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d            = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (enq_s) begin
      ent_vld_d[wr_ptr_q]  = 1'b1;
      ent_rd_d[wr_ptr_q]   = ld_rd;
      ent_data_d[wr_ptr_q] = ld_data;
      wr_ptr_d             = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      squash_hit_s[i] = alu_wr_s & ent_vld_d[i] & (ent_rd_d[i] == alu_rd);
    end
    ent_vld_d = ent_vld_d & ~squash_hit_s;
    case ({enq_s, pop_s})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Output register selection and starvation guard.
  always_comb begin
    if (alu_wr_s) begin
      regwrite_d = 1'b1;
      rd_d       = alu_rd;
      rd_data_d  = alu_data;
    end else if (drain_s) begin
      regwrite_d = 1'b1;
      rd_d       = ent_rd_q[rd_ptr_q];
      rd_data_d  = ent_data_q[rd_ptr_q];
    end else begin
      regwrite_d = 1'b0;
      rd_d       = 5'd0;
      rd_data_d  = 32'd0;
    end
    if (!head_avail_s || pop_s || !alu_ready_q) begin
      starve_d = 8'd0;
    end else if (head_vld_s && alu_wr_s) begin
      starve_d = starve_q + 8'd1;
    end else begin
      starve_d = starve_q;
    end
    // Hitting the limit withholds alu_ready for one cycle so the head is guaranteed the port.
    alu_ready_d = (starve_d != 8'(STARVE_LIMIT));
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_rd_q[i]   <= 5'd0;
        ent_data_q[i] <= 32'd0;
      end
      ent_vld_q   <= {DEPTH{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      wr_ptr_q    <= {AW{1'b0}};
      occ_q       <= {OW{1'b0}};
      starve_q    <= 8'd0;
      alu_ready_q <= 1'b1;
      regwrite_q  <= 1'b0;
      rd_q        <= 5'd0;
      rd_data_q   <= 32'd0;
    end else begin
      ent_rd_q    <= ent_rd_d;
      ent_data_q  <= ent_data_d;
      ent_vld_q   <= ent_vld_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      starve_q    <= starve_d;
      alu_ready_q <= alu_ready_d;
      regwrite_q  <= regwrite_d;
      rd_q        <= rd_d;
      rd_data_q   <= rd_data_d;
    end
  end

`ifdef WB_STATS_EN
  logic [31:0] wb_count_q;
  logic [15:0] squash_count_q;
  logic [16:0] squash_sum_s;

  assign wb_count     = wb_count_q;
  assign squash_count = squash_count_q;

  // Squash total for this cycle, saturating at the counter maximum.
  always_comb begin
    squash_sum_s = {1'b0, squash_count_q} + 17'($countones(squash_hit_s));
  end

  // Statistics counters: writes wrap, squashes saturate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_count_q     <= 32'd0;
      squash_count_q <= 16'd0;
    end else begin
      wb_count_q     <= wb_count_q + {31'd0, regwrite_q};
      squash_count_q <= squash_sum_s[16] ? 16'hFFFF : squash_sum_s[15:0];
    end
  end
`endif

endmodule
